// File: rtl/register_arbiter.sv
// Purpose : round-robin write arbiter sharing one enable-gated WIDTH-bit register among N requesters,
//           with a bounded lock for multi-cycle exclusive ownership.
// Latency : 1 cycle; req/lock/wdata sampled at edge t drive gnt/reg_en/reg_d after edge t.
// Backpres: none toward the register; a requester simply keeps req high until it sees its gnt bit.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   req[N]          per-requester write request (level)
//   lock[N]         per-requester hold request, only honoured for the winner / current owner
//   wdata[N*WIDTH]  requester i data in bits [i*WIDTH +: WIDTH]
//   gnt[N]          registered one-hot grant
//   reg_en, reg_d   registered enable/data pair to the shared register
//   owner           index of current grantee (meaningful while busy=1)
//   busy            high while any gnt bit is high

module register_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N-1:0]                  req,
    input  logic [N-1:0]                  lock,
    input  logic [N*WIDTH-1:0]            wdata,
    output logic [N-1:0]                  gnt,
    output logic                          reg_en,
    output logic [WIDTH-1:0]              reg_d,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner,
    output logic                          busy
);

    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [OW-1:0] LAST_IDX = OW'(N - 1);

    typedef enum logic {
        S_ARB  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q,    state_d;
    logic [N-1:0]     gnt_q,      gnt_d;
    logic [OW-1:0]    owner_q,    owner_d;
    logic             reg_en_q,   reg_en_d;
    logic [WIDTH-1:0] reg_d_q,    reg_d_d;
    logic             busy_q,     busy_d;
    logic [OW-1:0]    ptr_q,      ptr_d;
    logic [CW-1:0]    hold_cnt_q, hold_cnt_d;

    // ------------------------------------------------------------------
    // Per-requester data view
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] wdata_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_wdata
        assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------
    // Round-robin winner search
    // The current grantee is masked so a non-locked requester can never
    // win two edges in a row; this is what gives a lone requester its
    // every-other-cycle grant pattern.
    // ------------------------------------------------------------------
    logic [N-1:0]  cand;
    logic          win_vld;
    logic [OW-1:0] win_idx;
    logic [OW-1:0] win_next;

    assign cand = req & ~gnt_q;

    always_comb begin : p_scan
        logic [OW:0] pos;
        win_vld = 1'b0;
        win_idx = '0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            // pointer + k, wrapped modulo N (N need not be a power of two)
            pos = {1'b0, ptr_q} + (OW+1)'(k);
            if (pos >= (OW+1)'(N)) begin
                pos = pos - (OW+1)'(N);
            end
            if (!win_vld && cand[pos[OW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = pos[OW-1:0];
            end
        end
    end

    assign win_next = (win_idx == LAST_IDX) ? '0 : win_idx + OW'(1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic do_arb;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        reg_en_d   = 1'b0;
        reg_d_d    = reg_d_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        do_arb     = 1'b0;

        if (state_q == S_HOLD) begin
            // Owner drops lock, or has used its full allowance: release and
            // re-arbitrate on this same edge with the owner masked.
            if (!lock[owner_q] || (hold_cnt_q == HOLD_MAX)) begin
                do_arb = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + CW'(1);
                // Ownership is kept even if the owner is idle this cycle;
                // only the write itself is suppressed.
                reg_en_d   = req[owner_q];
                if (req[owner_q]) begin
                    reg_d_d = wdata_arr[owner_q];
                end
            end
        end else begin
            do_arb = 1'b1;
        end

        if (do_arb) begin
            state_d    = S_ARB;
            hold_cnt_d = '0;
            if (win_vld) begin
                gnt_d          = '0;
                gnt_d[win_idx] = 1'b1;
                owner_d        = win_idx;
                reg_en_d       = 1'b1;
                reg_d_d        = wdata_arr[win_idx];
                ptr_d          = win_next;
                // The entry cycle counts as the first held cycle.
                if (lock[win_idx]) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = CW'(1);
                end
            end else begin
                gnt_d = '0;
            end
        end

        busy_d = |gnt_d;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_ARB;
            gnt_q      <= '0;
            owner_q    <= '0;
            reg_en_q   <= 1'b0;
            reg_d_q    <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            reg_en_q   <= reg_en_d;
            reg_d_q    <= reg_d_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign owner  = owner_q;
    assign reg_en = reg_en_q;
    assign reg_d  = reg_d_q;
    assign busy   = busy_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_q));
    a_en_needs_gnt : assert property (@(posedge clk) disable iff (!rst) reg_en_q |-> (|gnt_q));
    a_busy_match : assert property (@(posedge clk) disable iff (!rst) busy_q == (|gnt_q));
    a_hold_bound : assert property (@(posedge clk) disable iff (!rst) hold_cnt_q <= HOLD_MAX);

endmodule

// File: tb/tb_register_arbiter.sv
module tb_register_arbiter;

    localparam int N        = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N-1:0]         lock;
    logic [N*WIDTH-1:0]   wdata;
    logic [N-1:0]         gnt;
    logic                 reg_en;
    logic [WIDTH-1:0]     reg_d;
    logic [1:0]           owner;
    logic                 busy;

    // Model of the shared enable-gated register fed by the arbiter
    logic [WIDTH-1:0]     q;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    register_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .wdata  (wdata),
        .gnt    (gnt),
        .reg_en (reg_en),
        .reg_d  (reg_d),
        .owner  (owner),
        .busy   (busy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        q <= '0;
        else if (reg_en) q <= reg_d;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        req   = '0;
        lock  = '0;
        wdata = '0;
        #2;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt got %b want 0000", gnt); end
        n_cmp++; if (reg_en !== 1'b0) begin n_bad++; $display("FAIL rst_en got %b want 0", reg_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        wdata = {8'd4, 8'd3, 8'd2, 8'd1};
        req   = 4'b1111;
        step();
        step();
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL pre_rst_gnt got %b want 0010", gnt); end
        n_cmp++; if (reg_en !== 1'b1) begin n_bad++; $display("FAIL pre_rst_en got %b want 1", reg_en); end
        // Async reset between edges
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL async_gnt got %b want 0000", gnt); end
        n_cmp++; if (reg_en !== 1'b0) begin n_bad++; $display("FAIL async_en got %b want 0", reg_en); end
        n_cmp++; if (reg_d !== 8'd0) begin n_bad++; $display("FAIL async_d got %0d want 0", reg_d); end
        n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL async_owner got %0d want 0", owner); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_busy got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        step();
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL post_rst_gnt got %b want 0001", gnt); end
        n_cmp++; if (reg_d !== 8'd1) begin n_bad++; $display("FAIL post_rst_d got %0d want 1", reg_d); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_gnt [5];
        logic [7:0] exp_d   [5];
        logic [1:0] exp_own [5];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d   = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd10};
        exp_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        wdata = {8'd13, 8'd12, 8'd11, 8'd10};
        req   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (gnt !== exp_gnt[i]) begin n_bad++; $display("FAIL rot_gnt[%0d] got %b want %b", i, gnt, exp_gnt[i]); end
            n_cmp++; if (reg_d !== exp_d[i]) begin n_bad++; $display("FAIL rot_d[%0d] got %0d want %0d", i, reg_d, exp_d[i]); end
            n_cmp++; if (reg_en !== 1'b1) begin n_bad++; $display("FAIL rot_en[%0d] got %b want 1", i, reg_en); end
            n_cmp++; if (owner !== exp_own[i]) begin n_bad++; $display("FAIL rot_owner[%0d] got %0d want %0d", i, owner, exp_own[i]); end
        end
    endtask

    task automatic test_lone();
        logic [3:0] exp_gnt [4];
        logic       exp_en  [4];
        exp_gnt = '{4'b0100, 4'b0000, 4'b0100, 4'b0000};
        exp_en  = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        wdata = {8'h00, 8'h55, 8'h00, 8'h00};
        req   = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step();
            // Churn a non-granted input; must never reach reg_d
            wdata[7:0] = 8'(8'hA0 + i);
            n_cmp++; if (gnt !== exp_gnt[i]) begin n_bad++; $display("FAIL lone_gnt[%0d] got %b want %b", i, gnt, exp_gnt[i]); end
            n_cmp++; if (reg_en !== exp_en[i]) begin n_bad++; $display("FAIL lone_en[%0d] got %b want %b", i, reg_en, exp_en[i]); end
            n_cmp++; if (reg_d !== 8'h55) begin n_bad++; $display("FAIL lone_d[%0d] got %h want 55", i, reg_d); end
        end
        n_cmp++; if (q !== 8'h55) begin n_bad++; $display("FAIL lone_q got %h want 55", q); end
    endtask

    task automatic test_lock_release();
        do_reset();
        wdata = {8'd0, 8'd0, 8'd50, 8'd31};
        req   = 4'b0011;
        lock  = 4'b0001;
        step();
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL lk_gnt0 got %b want 0001", gnt); end
        n_cmp++; if (reg_d !== 8'd31) begin n_bad++; $display("FAIL lk_d0 got %0d want 31", reg_d); end
        wdata[7:0] = 8'd127;
        step();
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL lk_gnt1 got %b want 0001", gnt); end
        n_cmp++; if (reg_d !== 8'd127) begin n_bad++; $display("FAIL lk_d1 got %0d want 127", reg_d); end
        n_cmp++; if (reg_en !== 1'b1) begin n_bad++; $display("FAIL lk_en1 got %b want 1", reg_en); end
        lock = 4'b0000;
        step();
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL lk_gnt2 got %b want 0010", gnt); end
        n_cmp++; if (reg_d !== 8'd50) begin n_bad++; $display("FAIL lk_d2 got %0d want 50", reg_d); end
    endtask

    task automatic test_forced_release();
        logic [3:0] exp_gnt [7];
        exp_gnt = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0100};
        do_reset();
        wdata = {8'd0, 8'd22, 8'd21, 8'd0};
        req   = 4'b0110;
        lock  = 4'b0100;
        for (int i = 0; i < 7; i++) begin
            step();
            n_cmp++; if (gnt !== exp_gnt[i]) begin n_bad++; $display("FAIL frc_gnt[%0d] got %b want %b", i, gnt, exp_gnt[i]); end
            n_cmp++; if (reg_en !== 1'b1) begin n_bad++; $display("FAIL frc_en[%0d] got %b want 1", i, reg_en); end
        end
    endtask

    task automatic test_owner_idle();
        do_reset();
        wdata = {8'd0, 8'd0, 8'd12, 8'd0};
        req   = 4'b0010;
        lock  = 4'b0010;
        step();
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL idle_gnt0 got %b want 0010", gnt); end
        req = 4'b0000;
        wdata[15:8] = 8'd77;
        step();
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL idle_gnt1 got %b want 0010", gnt); end
        n_cmp++; if (reg_en !== 1'b0) begin n_bad++; $display("FAIL idle_en1 got %b want 0", reg_en); end
        n_cmp++; if (reg_d !== 8'd12) begin n_bad++; $display("FAIL idle_d1 got %0d want 12", reg_d); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL idle_busy1 got %b want 1", busy); end
        req = 4'b0010;
        step();
        n_cmp++; if (q !== 8'd12) begin n_bad++; $display("FAIL idle_q got %0d want 12", q); end
        n_cmp++; if (reg_d !== 8'd77) begin n_bad++; $display("FAIL idle_d2 got %0d want 77", reg_d); end
        req  = 4'b0000;
        lock = 4'b0000;
        step();
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL idle_gnt3 got %b want 0000", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy3 got %b want 0", busy); end
        n_cmp++; if (q !== 8'd77) begin n_bad++; $display("FAIL idle_q3 got %0d want 77", q); end
    endtask

    task automatic test_nonowner_lock();
        do_reset();
        req  = 4'b0011;
        lock = 4'b0010;
        step();
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL nol_gnt0 got %b want 0001", gnt); end
        lock = 4'b0000;
        step();
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL nol_gnt1 got %b want 0010", gnt); end
        step();
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL nol_gnt2 got %b want 0001", gnt); end
    endtask

    initial begin
        rst   = 1'b0;
        req   = '0;
        lock  = '0;
        wdata = '0;
        test_reset();
        test_rotation();
        test_lone();
        test_lock_release();
        test_forced_release();
        test_owner_idle();
        test_nonowner_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
